// File: rtl/usb_tx_pkg.sv
// Shared types and constants for the USB TX line-coding stage.
// Holds the stuff FSM state type, the idle (J) line level and default run length.
package usb_tx_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    TAIL
  } stuff_state_t;

  localparam logic USB_J_LEVEL     = 1'b1;
  localparam int   USB_DEF_RUN_LEN = 6;

endpackage

// File: rtl/usb_run_counter.sv
// Run-of-ones counter for bit stuffing: clear has priority, inc saturates.
// Ports: clk, n_rst (sync, active low), inc, clr -> at_max (count == RUN_LEN).
module usb_run_counter #(
  parameter int RUN_LEN = 6,
  parameter int CNT_W   = $clog2(RUN_LEN + 1)
) (
  input  logic clk,
  input  logic n_rst,
  input  logic inc,
  input  logic clr,
  output logic at_max
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign at_max = (cnt_q == CNT_W'(RUN_LEN));

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && !at_max) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/usb_tx_stuff_nrzi.sv
// USB TX bit stuffing fused with NRZI encoding; owns the trailing stuff bit.
// Ports: clk, n_rst, bit_tick, tx_active, data_in -> shift_hold, nrzi_out,
// stuff_done, and stuff_cnt when USB_STUFF_STATS_EN is defined.
module usb_tx_stuff_nrzi
  import usb_tx_pkg::*;
#(
  parameter int RUN_LEN = USB_DEF_RUN_LEN,
  parameter int CNT_W   = $clog2(RUN_LEN + 1),
  parameter int STAT_W  = 8
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              bit_tick,
  input  logic              tx_active,
  input  logic              data_in,
  output logic              shift_hold,
  output logic              nrzi_out,
  output logic              stuff_done
`ifdef USB_STUFF_STATS_EN
  ,
  output logic [STAT_W-1:0] stuff_cnt
`endif
);

  stuff_state_t state_q;
  stuff_state_t state_d;
  logic         nrzi_q;
  logic         nrzi_d;
  logic         done_q;
  logic         done_d;
  logic         run_inc;
  logic         run_clr;
  logic         at_max;
  logic         start_now;
  logic         stuff_now;

  usb_run_counter #(
    .RUN_LEN (RUN_LEN),
    .CNT_W   (CNT_W)
  ) u_run (
    .clk    (clk),
    .n_rst  (n_rst),
    .inc    (run_inc),
    .clr    (run_clr),
    .at_max (at_max)
  );

  assign shift_hold = (state_q == DATA) && at_max;
  assign nrzi_out   = nrzi_q;
  assign stuff_done = done_q;

  // A stuff bit goes out whenever the run is full, whether or not
  // the payload is still active (the inactive case is the tail bit).
  assign start_now = bit_tick && (state_q == IDLE) && tx_active;
  assign stuff_now = bit_tick && shift_hold;

  always_comb begin
    state_d = state_q;
    nrzi_d  = nrzi_q;
    done_d  = 1'b0;
    run_inc = 1'b0;
    run_clr = 1'b0;
    if (bit_tick) begin
      unique case (state_q)
        IDLE: begin
          if (tx_active) begin
            state_d = DATA;
            run_inc = data_in;
            run_clr = !data_in;
            nrzi_d  = data_in ? nrzi_q : !nrzi_q;
          end
        end
        DATA: begin
          unique case (1'b1)
            tx_active && at_max: begin
              run_clr = 1'b1;
              nrzi_d  = !nrzi_q;
            end
            tx_active && !at_max: begin
              run_inc = data_in;
              run_clr = !data_in;
              nrzi_d  = data_in ? nrzi_q : !nrzi_q;
            end
            !tx_active && at_max: begin
              state_d = TAIL;
              run_clr = 1'b1;
              nrzi_d  = !nrzi_q;
            end
            default: begin
              state_d = IDLE;
              run_clr = 1'b1;
              done_d  = 1'b1;
            end
          endcase
        end
        TAIL: begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
        default: begin
          state_d = IDLE;
          run_clr = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q <= IDLE;
      nrzi_q  <= USB_J_LEVEL;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      nrzi_q  <= nrzi_d;
      done_q  <= done_d;
    end
  end

`ifdef USB_STUFF_STATS_EN
  logic [STAT_W-1:0] stat_q;
  logic [STAT_W-1:0] stat_d;

  assign stuff_cnt = stat_q;

  always_comb begin
    stat_d = stat_q;
    if (start_now) begin
      stat_d = '0;
    end else if (stuff_now && (stat_q != '1)) begin
      stat_d = stat_q + STAT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      stat_q <= '0;
    end else begin
      stat_q <= stat_d;
    end
  end
`else
  logic unused_ok;
  assign unused_ok = start_now ^ stuff_now;
`endif

endmodule

// File: tb/tb_usb_tx_stuff_nrzi.sv
// Self-checking bench: two DUTs (RUN_LEN=6/STAT_W=8 and RUN_LEN=1/STAT_W=2)
// checked per bit time against a stuffed-stream + NRZI reference model.
module tb_usb_tx_stuff_nrzi;

  logic clk = 1'b0;
  logic n_rst;
  logic tick [2];
  logic act  [2];
  logic din  [2];
  logic hold_a, hold_b;
  logic nrzi_a, nrzi_b;
  logic done_a, done_b;
`ifdef USB_STUFF_STATS_EN
  logic [7:0] cnt_a;
  logic [1:0] cnt_b;
`endif

  int checks = 0;
  int errors = 0;
  bit lvl [2];
  bit pkt_q [$];

  always #5 clk = ~clk;

  usb_tx_stuff_nrzi #(.RUN_LEN(6), .STAT_W(8)) u_a (
    .clk        (clk),
    .n_rst      (n_rst),
    .bit_tick   (tick[0]),
    .tx_active  (act[0]),
    .data_in    (din[0]),
    .shift_hold (hold_a),
    .nrzi_out   (nrzi_a),
    .stuff_done (done_a)
`ifdef USB_STUFF_STATS_EN
    ,
    .stuff_cnt  (cnt_a)
`endif
  );

  usb_tx_stuff_nrzi #(.RUN_LEN(1), .STAT_W(2)) u_b (
    .clk        (clk),
    .n_rst      (n_rst),
    .bit_tick   (tick[1]),
    .tx_active  (act[1]),
    .data_in    (din[1]),
    .shift_hold (hold_b),
    .nrzi_out   (nrzi_b),
    .stuff_done (done_b)
`ifdef USB_STUFF_STATS_EN
    ,
    .stuff_cnt  (cnt_b)
`endif
  );

  function automatic int rl_of(input int d);
    return (d == 0) ? 6 : 1;
  endfunction

  function automatic logic hold_of(input int d);
    return (d == 0) ? hold_a : hold_b;
  endfunction

  function automatic logic nrzi_of(input int d);
    return (d == 0) ? nrzi_a : nrzi_b;
  endfunction

  function automatic logic done_of(input int d);
    return (d == 0) ? done_a : done_b;
  endfunction

  // tmode: 0 = trailing stuff sent with tx_active=1,
  // 1 = trailing stuff via tx_active=0 (TAIL), 2 = random choice.
  task automatic run_pkt(input int d, input string nm, input int tmode);
    bit sb [$];
    bit sf [$];
    int ones;
    int ns;
    int last;
    bit tailm;
    ones = 0;
    ns   = 0;
    foreach (pkt_q[i]) begin
      sb.push_back(pkt_q[i]);
      sf.push_back(1'b0);
      ones = pkt_q[i] ? ones + 1 : 0;
      if (ones == rl_of(d)) begin
        sb.push_back(1'b0);
        sf.push_back(1'b1);
        ones = 0;
        ns++;
      end
    end
    last  = sb.size() - 1;
    tailm = sf[last] && ((tmode == 1) ||
            ((tmode == 2) && ($urandom_range(0, 1) == 1)));
    for (int k = 0; k <= last; k++) begin
      @(negedge clk);
      checks++;
      if (hold_of(d) !== sf[k]) begin
        errors++;
        $display("FAIL %s hold k=%0d got %b exp %b",
                 nm, k, hold_of(d), sf[k]);
      end
      checks++;
      if (done_of(d) !== 1'b0) begin
        errors++;
        $display("FAIL %s early_done k=%0d got %b exp 0",
                 nm, k, done_of(d));
      end
      tick[d] = 1'b1;
      act[d]  = !(tailm && (k == last));
      din[d]  = sf[k] ? 1'($urandom_range(0, 1)) : sb[k];
      @(posedge clk);
      #1;
      tick[d] = 1'b0;
      if (!sb[k]) lvl[d] = ~lvl[d];
      checks++;
      if (nrzi_of(d) !== lvl[d]) begin
        errors++;
        $display("FAIL %s nrzi k=%0d got %b exp %b",
                 nm, k, nrzi_of(d), lvl[d]);
      end
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end
    @(negedge clk);
    checks++;
    if (hold_of(d) !== 1'b0) begin
      errors++;
      $display("FAIL %s end_hold got %b exp 0", nm, hold_of(d));
    end
    tick[d] = 1'b1;
    act[d]  = tailm ? 1'($urandom_range(0, 1)) : 1'b0;
    din[d]  = 1'($urandom_range(0, 1));
    @(posedge clk);
    #1;
    tick[d] = 1'b0;
    act[d]  = 1'b0;
    checks++;
    if (nrzi_of(d) !== lvl[d]) begin
      errors++;
      $display("FAIL %s end_nrzi got %b exp %b", nm, nrzi_of(d), lvl[d]);
    end
    checks++;
    if (done_of(d) !== 1'b1) begin
      errors++;
      $display("FAIL %s done got %b exp 1", nm, done_of(d));
    end
    @(posedge clk);
    #1;
    checks++;
    if (done_of(d) !== 1'b0) begin
      errors++;
      $display("FAIL %s done_width got %b exp 0", nm, done_of(d));
    end
`ifdef USB_STUFF_STATS_EN
    begin
      int smax;
      int got;
      int exp_c;
      smax  = (d == 0) ? 255 : 3;
      got   = (d == 0) ? int'(cnt_a) : int'(cnt_b);
      exp_c = (ns > smax) ? smax : ns;
      checks++;
      if (got !== exp_c) begin
        errors++;
        $display("FAIL %s stuff_cnt got %0d exp %0d", nm, got, exp_c);
      end
    end
`endif
  endtask

  task automatic idle_ticks(input int d, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      tick[d] = 1'b1;
      act[d]  = 1'b0;
      din[d]  = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      tick[d] = 1'b0;
      checks++;
      if (nrzi_of(d) !== lvl[d] || done_of(d) !== 1'b0) begin
        errors++;
        $display("FAIL idle d=%0d nrzi %b done %b exp %b 0",
                 d, nrzi_of(d), done_of(d), lvl[d]);
      end
    end
  endtask

  task automatic set_pkt(input int n, input bit v);
    pkt_q.delete();
    for (int i = 0; i < n; i++) pkt_q.push_back(v);
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (nrzi_a !== 1'b1 || hold_a !== 1'b0 || done_a !== 1'b0) begin
      errors++;
      $display("FAIL reset_a nrzi %b hold %b done %b exp 1 0 0",
               nrzi_a, hold_a, done_a);
    end
    checks++;
    if (nrzi_b !== 1'b1 || hold_b !== 1'b0 || done_b !== 1'b0) begin
      errors++;
      $display("FAIL reset_b nrzi %b hold %b done %b exp 1 0 0",
               nrzi_b, hold_b, done_b);
    end
`ifdef USB_STUFF_STATS_EN
    checks++;
    if (cnt_a !== 8'd0 || cnt_b !== 2'd0) begin
      errors++;
      $display("FAIL reset_cnt got %0d %0d exp 0 0", cnt_a, cnt_b);
    end
`endif
    @(negedge clk);
    n_rst  = 1'b1;
    lvl[0] = 1'b1;
    lvl[1] = 1'b1;
  endtask

  task automatic test_zeros();
    set_pkt(8, 1'b0);
    run_pkt(0, "zeros", 2);
  endtask

  task automatic test_ones();
    set_pkt(8, 1'b1);
    run_pkt(0, "ones", 2);
  endtask

  task automatic test_tail();
    set_pkt(2, 1'b0);
    for (int i = 0; i < 6; i++) pkt_q.push_back(1'b1);
    run_pkt(0, "tail_t", 1);
    idle_ticks(0, 1);
    run_pkt(0, "tail_a", 0);
  endtask

  task automatic test_runlen1();
    set_pkt(3, 1'b1);
    run_pkt(1, "rl1", 1);
    idle_ticks(1, 2);
  endtask

  task automatic test_saturate();
    set_pkt(5, 1'b1);
    run_pkt(1, "sat", 2);
  endtask

  task automatic test_mid_reset();
    pkt_q.delete();
    pkt_q.push_back(1'b0);
    for (int i = 0; i < 5; i++) pkt_q.push_back(1'b1);
    foreach (pkt_q[i]) begin
      @(negedge clk);
      tick[0] = 1'b1;
      act[0]  = 1'b1;
      din[0]  = pkt_q[i];
      @(posedge clk);
      #1;
      tick[0] = 1'b0;
    end
    @(negedge clk);
    n_rst = 1'b0;
    @(posedge clk);
    #1;
    act[0] = 1'b0;
    checks++;
    if (nrzi_a !== 1'b1 || hold_a !== 1'b0 || done_a !== 1'b0) begin
      errors++;
      $display("FAIL midrst nrzi %b hold %b done %b exp 1 0 0",
               nrzi_a, hold_a, done_a);
    end
    @(negedge clk);
    n_rst  = 1'b1;
    lvl[0] = 1'b1;
    lvl[1] = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (done_a !== 1'b0) begin
      errors++;
      $display("FAIL midrst_done got %b exp 0", done_a);
    end
    set_pkt(7, 1'b1);
    pkt_q.push_back(1'b0);
    run_pkt(0, "post_rst", 2);
  endtask

  task automatic test_random();
    for (int p = 0; p < 24; p++) begin
      int d;
      int n;
      d = p % 2;
      n = $urandom_range(1, 24);
      pkt_q.delete();
      for (int i = 0; i < n; i++)
        pkt_q.push_back($urandom_range(0, 3) != 0);
      run_pkt(d, "rand", 2);
      idle_ticks(d, $urandom_range(0, 2));
    end
  endtask

  task automatic test_back_to_back();
    for (int p = 0; p < 4; p++) begin
      pkt_q.delete();
      for (int i = 0; i < 10; i++)
        pkt_q.push_back($urandom_range(0, 4) != 0);
      run_pkt(0, "b2b", 2);
    end
  endtask

  initial begin
    n_rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      tick[d] = 1'b0;
      act[d]  = 1'b0;
      din[d]  = 1'b0;
      lvl[d]  = 1'b1;
    end
    test_reset();
    test_zeros();
    test_ones();
    test_tail();
    test_runlen1();
    test_saturate();
    test_mid_reset();
    test_random();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
